// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcodes and FSM encoding for the ALU command sequencer
// Contents: opcode constants forwarded to the ALU, 2-bit sequencer state encoding,
//           and the width of one packed command word {op, a, b, addr}.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_SUB    = 3'b001;
    localparam logic [2:0] OP_MEM_RD = 3'b100;
    localparam logic [2:0] OP_MEM_WR = 3'b110;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ISSUE = 2'b01;
    localparam logic [1:0] ST_WAIT  = 2'b10;

    function automatic int cmd_width(input int op_w, input int data_w, input int addr_w);
        return op_w + 2 * data_w + addr_w;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - synchronous command FIFO with occupancy count
// Ports: clk/reset (sync, active-high), push/wdata write side, pop/rdata read side
//        (rdata shows the head entry without a pop), full/empty flags, count occupancy.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 11
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not flushed on reset; the pointers make stale entries invisible.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    assign rdata = mem[rptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - queues ALU commands, issues them one at a time, holds each result
// Ports: clk/reset (sync, active-high); cmd_* command input with cmd_valid/cmd_ready;
//        alu_* start pulse, operands and done/result handshake to the multi-cycle ALU;
//        res_* single-entry result slot with res_valid/res_ready; busy and FIFO count status.
module alu_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int DATA_W  = 2,
    parameter int RES_W   = 3,
    parameter int OP_W    = 3,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [OP_W-1:0]        cmd_op,
    input  logic [DATA_W-1:0]      cmd_a,
    input  logic [DATA_W-1:0]      cmd_b,
    input  logic [ADDR_W-1:0]      cmd_addr,
    output logic                   alu_start,
    output logic [DATA_W-1:0]      alu_A,
    output logic [DATA_W-1:0]      alu_B,
    output logic [OP_W-1:0]        alu_Op,
    output logic [ADDR_W-1:0]      alu_Address,
    input  logic [RES_W-1:0]       alu_Y,
    input  logic [RES_W-1:0]       alu_MemOut,
    input  logic                   alu_done,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [RES_W-1:0]       res_y,
    output logic [RES_W-1:0]       res_mem,
    output logic [OP_W-1:0]        res_op,
    output logic                   res_timeout,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count
);

    import alu_seq_pkg::*;

    localparam int CMD_W = cmd_width(OP_W, DATA_W, ADDR_W);
    localparam int TW    = $clog2(TIMEOUT + 1);

    logic [1:0]       state;
    logic [TW-1:0]    timer;
    logic [CMD_W-1:0] fifo_wdata;
    logic [CMD_W-1:0] fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;

    assign fifo_wdata = {cmd_op, cmd_a, cmd_b, cmd_addr};

    // A new command leaves the queue only when the result slot is free, so at most
    // one operation is ever in flight or waiting to be consumed.
    assign fifo_pop = (state == ST_IDLE) && !fifo_empty && !res_valid;

    alu_cmd_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(CMD_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cmd_valid),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    assign cmd_ready = !fifo_full;
    assign alu_start = (state == ST_ISSUE);
    assign busy      = (state != ST_IDLE) || !fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            timer       <= '0;
            alu_A       <= '0;
            alu_B       <= '0;
            alu_Op      <= '0;
            alu_Address <= '0;
            res_valid   <= 1'b0;
            res_y       <= '0;
            res_mem     <= '0;
            res_op      <= '0;
            res_timeout <= 1'b0;
        end else begin
            if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        {alu_Op, alu_A, alu_B, alu_Address} <= fifo_rdata;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    timer <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // done is checked first so a completion on the last allowed
                    // cycle is reported as a normal result.
                    if (alu_done) begin
                        res_valid   <= 1'b1;
                        res_y       <= alu_Y;
                        res_mem     <= alu_MemOut;
                        res_op      <= alu_Op;
                        res_timeout <= 1'b0;
                        state       <= ST_IDLE;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        res_valid   <= 1'b1;
                        res_y       <= '0;
                        res_mem     <= '0;
                        res_op      <= alu_Op;
                        res_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - self-checking bench for alu_cmd_sequencer
module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [1:0] cmd_a;
    logic [1:0] cmd_b;
    logic [3:0] cmd_addr;
    logic       alu_start;
    logic [1:0] alu_A;
    logic [1:0] alu_B;
    logic [2:0] alu_Op;
    logic [3:0] alu_Address;
    logic [2:0] alu_Y;
    logic [2:0] alu_MemOut;
    logic       alu_done;
    logic       res_valid;
    logic       res_ready;
    logic [2:0] res_y;
    logic [2:0] res_mem;
    logic [2:0] res_op;
    logic       res_timeout;
    logic       busy;
    logic [2:0] count;

    alu_cmd_sequencer #(
        .DEPTH(4), .DATA_W(2), .RES_W(3), .OP_W(3), .ADDR_W(4), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_addr(cmd_addr),
        .alu_start(alu_start), .alu_A(alu_A), .alu_B(alu_B), .alu_Op(alu_Op),
        .alu_Address(alu_Address), .alu_Y(alu_Y), .alu_MemOut(alu_MemOut),
        .alu_done(alu_done),
        .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y),
        .res_mem(res_mem), .res_op(res_op), .res_timeout(res_timeout),
        .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [1:0] a;
        logic [1:0] b;
        logic [3:0] addr;
    } cmd_t;

    typedef struct {
        logic [2:0] op;
        logic [2:0] y;
        logic [2:0] mem;
        logic       to;
    } res_t;

    cmd_t issue_q[$];
    res_t exp_q[$];
    int   lat_q[$];

    logic [2:0] ref_mem [16];
    logic [2:0] alu_mem [16];

    int   tests = 0;
    int   fails = 0;
    int   start_cnt = 0;
    bit   have_issued = 1'b0;
    bit   alu_manual = 1'b0;
    bit   rr_random = 1'b0;
    cmd_t last_issued;
    cmd_t mon_c;
    res_t mon_r;

    // Behaviour of the ALU being sequenced: arithmetic on Y, memory read data on MemOut.
    function automatic logic [2:0] alu_y(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b);
        case (op)
            OP_ADD:               return 3'(a) + 3'(b);
            OP_SUB:               return 3'(a) - 3'(b);
            OP_MEM_RD, OP_MEM_WR: return 3'd0;
            default:              return {1'b0, a ^ b};
        endcase
    endfunction

    // ALU responder: done arrives 'lat' cycles after the start cycle; lat 0 = never.
    logic [2:0] r_op;
    logic [1:0] r_a;
    logic [1:0] r_b;
    logic [3:0] r_addr;
    int         pend = 0;
    bit         rst_s;
    initial begin
        alu_done   = 1'b0;
        alu_Y      = 3'd0;
        alu_MemOut = 3'd0;
        forever begin
            @(posedge clk);
            rst_s = reset;
            #1;
            if (!alu_manual) begin
                alu_done   = 1'b0;
                alu_Y      = 3'($urandom);
                alu_MemOut = 3'($urandom);
                if (rst_s) begin
                    pend = 0;
                end else begin
                    if (pend > 0) begin
                        pend--;
                        if (pend == 0) begin
                            alu_done   = 1'b1;
                            alu_Y      = alu_y(r_op, r_a, r_b);
                            alu_MemOut = alu_mem[r_addr];
                            if (r_op == OP_MEM_WR) alu_mem[r_addr] = {1'b0, r_a};
                        end
                    end
                    if (alu_start) begin
                        pend   = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
                        r_op   = alu_Op;
                        r_a    = alu_A;
                        r_b    = alu_B;
                        r_addr = alu_Address;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rr_random) res_ready = 1'($urandom_range(0, 1));
        end
    end

    // Issue-order, operand-hold and result scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (alu_start) begin
            start_cnt++;
            tests++;
            if (issue_q.size() == 0) begin
                fails++;
                $display("FAIL issue_extra: alu_start with nothing queued, op=%b", alu_Op);
            end else begin
                mon_c = issue_q.pop_front();
                if ({alu_Op, alu_A, alu_B, alu_Address} !== {mon_c.op, mon_c.a, mon_c.b, mon_c.addr}) begin
                    fails++;
                    $display("FAIL issue_order: got op=%b a=%b b=%b addr=%b, want op=%b a=%b b=%b addr=%b",
                             alu_Op, alu_A, alu_B, alu_Address, mon_c.op, mon_c.a, mon_c.b, mon_c.addr);
                end
                last_issued = mon_c;
                have_issued = 1'b1;
            end
        end else if (have_issued) begin
            tests++;
            if ({alu_Op, alu_A, alu_B, alu_Address} !== {last_issued.op, last_issued.a, last_issued.b, last_issued.addr}) begin
                fails++;
                $display("FAIL operand_hold: got op=%b a=%b b=%b addr=%b, want op=%b a=%b b=%b addr=%b",
                         alu_Op, alu_A, alu_B, alu_Address, last_issued.op, last_issued.a, last_issued.b, last_issued.addr);
            end
        end
        if (res_valid && res_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL result_extra: result op=%b y=%b with none expected", res_op, res_y);
            end else begin
                mon_r = exp_q.pop_front();
                if ({res_op, res_y, res_mem, res_timeout} !== {mon_r.op, mon_r.y, mon_r.mem, mon_r.to}) begin
                    fails++;
                    $display("FAIL result: got op=%b y=%b mem=%b to=%b, want op=%b y=%b mem=%b to=%b",
                             res_op, res_y, res_mem, res_timeout, mon_r.op, mon_r.y, mon_r.mem, mon_r.to);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic cmd_t rand_cmd(input bit no_write);
        cmd_t c;
        c.op   = 3'($urandom_range(0, 7));
        c.a    = 2'($urandom);
        c.b    = 2'($urandom);
        c.addr = 4'($urandom);
        if (no_write && c.op == OP_MEM_WR) c.op = OP_ADD;
        return c;
    endfunction

    // Offers one command, waits for acceptance, and records what should follow from it.
    task automatic push_cmd(input cmd_t c, input int lat);
        res_t r;
        int   n = 0;
        cmd_valid = 1'b1;
        cmd_op    = c.op;
        cmd_a     = c.a;
        cmd_b     = c.b;
        cmd_addr  = c.addr;
        while (!cmd_ready && n < 300) begin
            step();
            n++;
        end
        tests++;
        if (!cmd_ready) begin
            fails++;
            $display("FAIL push_wait: cmd_ready stayed %b for %0d cycles, want 1", cmd_ready, n);
        end
        step();
        cmd_valid = 1'b0;
        r.op = c.op;
        if (lat == 0 || lat > TIMEOUT) begin
            r.y   = 3'd0;
            r.mem = 3'd0;
            r.to  = 1'b1;
        end else begin
            r.y   = alu_y(c.op, c.a, c.b);
            r.mem = ref_mem[c.addr];
            r.to  = 1'b0;
            if (c.op == OP_MEM_WR) ref_mem[c.addr] = {1'b0, c.a};
        end
        issue_q.push_back(c);
        lat_q.push_back(lat);
        exp_q.push_back(r);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy || res_valid) && n < budget) begin
            step();
            n++;
        end
        tests++;
        if (n >= budget) begin
            fails++;
            $display("FAIL drain: still busy=%b res_valid=%b pending=%0d after %0d cycles, want idle",
                     busy, res_valid, exp_q.size(), n);
        end
    endtask

    task automatic wait_res(input int budget);
        int n = 0;
        while (!res_valid && n < budget) begin
            step();
            n++;
        end
        tests++;
        if (!res_valid) begin
            fails++;
            $display("FAIL res_wait: res_valid=%b after %0d cycles, want 1", res_valid, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) step();
        tests++;
        if ({cmd_ready, count, busy, alu_start, res_valid} !== {1'b1, 3'd0, 1'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_ctl: got ready=%b count=%0d busy=%b start=%b rv=%b, want 1 0 0 0 0",
                     cmd_ready, count, busy, alu_start, res_valid);
        end
        tests++;
        if ({alu_A, alu_B, alu_Op, alu_Address, res_y, res_mem, res_op, res_timeout} !== 21'd0) begin
            fails++;
            $display("FAIL reset_data: got alu=%b/%b/%b/%b res=%b/%b/%b/%b, want all 0",
                     alu_A, alu_B, alu_Op, alu_Address, res_y, res_mem, res_op, res_timeout);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single();
        cmd_t c;
        int   s0 = start_cnt;
        res_ready = 1'b0;
        c.op = OP_ADD; c.a = 2'b01; c.b = 2'b10; c.addr = 4'd0;
        push_cmd(c, 3);
        tests++;
        if ({count, alu_start, busy} !== {3'd1, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL single_queued: got count=%0d start=%b busy=%b, want 1 0 1", count, alu_start, busy);
        end
        step();
        tests++;
        if ({alu_start, alu_Op, count} !== {1'b1, 3'b000, 3'd0}) begin
            fails++;
            $display("FAIL single_start: got start=%b op=%b count=%0d, want 1 000 0", alu_start, alu_Op, count);
        end
        step();
        tests++;
        if (alu_start !== 1'b0) begin
            fails++;
            $display("FAIL single_pulse: alu_start=%b one cycle after issue, want 0", alu_start);
        end
        wait_res(40);
        for (int i = 0; i < 5; i++) begin
            tests++;
            if ({res_valid, res_y, res_op, res_timeout} !== {1'b1, 3'b011, 3'b000, 1'b0}) begin
                fails++;
                $display("FAIL single_hold: got rv=%b y=%b op=%b to=%b, want 1 011 000 0",
                         res_valid, res_y, res_op, res_timeout);
            end
            step();
        end
        res_ready = 1'b1;
        step();
        tests++;
        if ({res_valid, start_cnt - s0} !== {1'b0, 32'd1}) begin
            fails++;
            $display("FAIL single_consume: got rv=%b starts=%0d, want 0 1", res_valid, start_cnt - s0);
        end
    endtask

    task automatic test_in_order();
        cmd_t c;
        res_ready = 1'b1;
        c.op = OP_MEM_WR; c.a = 2'b11; c.b = 2'b00; c.addr = 4'b0010;
        push_cmd(c, 2);
        c.op = OP_MEM_RD; c.a = 2'b00; c.b = 2'b00; c.addr = 4'b0010;
        push_cmd(c, 4);
        c.op = OP_SUB; c.a = 2'b11; c.b = 2'b01; c.addr = 4'b0000;
        push_cmd(c, 3);
        wait_idle(200);
    endtask

    task automatic test_full();
        int s0;
        res_ready = 1'b1;
        s0 = start_cnt;
        push_cmd(rand_cmd(1'b0), 12);
        repeat (2) step();
        for (int i = 0; i < 4; i++) push_cmd(rand_cmd(1'b0), 2 + int'($urandom_range(0, 2)));
        tests++;
        if ({count, cmd_ready} !== {3'd4, 1'b0}) begin
            fails++;
            $display("FAIL full_flag: got count=%0d ready=%b, want 4 0", count, cmd_ready);
        end
        push_cmd(rand_cmd(1'b0), 3);
        tests++;
        if ({count, start_cnt - s0} !== {3'd4, 32'd2}) begin
            fails++;
            $display("FAIL full_refill: got count=%0d starts=%0d, want 4 2", count, start_cnt - s0);
        end
        wait_idle(400);
    endtask

    task automatic test_backpressure();
        int s0 = start_cnt;
        res_ready = 1'b0;
        push_cmd(rand_cmd(1'b0), 3);
        push_cmd(rand_cmd(1'b0), 3);
        wait_res(40);
        for (int i = 0; i < 6; i++) begin
            tests++;
            if ({alu_start, count, start_cnt - s0} !== {1'b0, 3'd1, 32'd1}) begin
                fails++;
                $display("FAIL bp_withhold: got start=%b count=%0d starts=%0d, want 0 1 1",
                         alu_start, count, start_cnt - s0);
            end
            step();
        end
        res_ready = 1'b1;
        wait_idle(100);
    endtask

    task automatic test_timeout();
        int n = 0;
        res_ready = 1'b0;
        push_cmd(rand_cmd(1'b1), 0);
        push_cmd(rand_cmd(1'b0), 4);
        while (!alu_start && n < 20) begin
            step();
            n++;
        end
        n = 0;
        while (!res_valid && n < 100) begin
            step();
            n++;
        end
        tests++;
        if (n !== TIMEOUT + 1) begin
            fails++;
            $display("FAIL to_latency: result %0d cycles after start, want %0d", n, TIMEOUT + 1);
        end
        tests++;
        if ({res_valid, res_timeout, res_y, res_mem} !== {1'b1, 1'b1, 3'd0, 3'd0}) begin
            fails++;
            $display("FAIL to_fields: got rv=%b to=%b y=%b mem=%b, want 1 1 000 000",
                     res_valid, res_timeout, res_y, res_mem);
        end
        res_ready = 1'b1;
        push_cmd(rand_cmd(1'b0), TIMEOUT);
        push_cmd(rand_cmd(1'b1), TIMEOUT + 1);
        push_cmd(rand_cmd(1'b0), 2);
        wait_idle(300);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int s0;
        res_ready = 1'b1;
        push_cmd(rand_cmd(1'b1), 0);
        push_cmd(rand_cmd(1'b1), 3);
        while (!alu_start && n < 20) begin
            step();
            n++;
        end
        repeat (3) step();
        reset = 1'b1;
        step();
        tests++;
        if ({alu_start, res_valid, count, busy, cmd_ready} !== {1'b0, 1'b0, 3'd0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL midreset: got start=%b rv=%b count=%0d busy=%b ready=%b, want 0 0 0 0 1",
                     alu_start, res_valid, count, busy, cmd_ready);
        end
        reset = 1'b0;
        issue_q.delete();
        exp_q.delete();
        lat_q.delete();
        have_issued = 1'b0;
        s0 = start_cnt;
        alu_manual = 1'b1;
        alu_done   = 1'b1;
        alu_Y      = 3'b111;
        alu_MemOut = 3'b101;
        step();
        alu_done   = 1'b0;
        alu_manual = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if ({res_valid, busy, start_cnt - s0} !== {1'b0, 1'b0, 32'd0}) begin
                fails++;
                $display("FAIL stray_done: got rv=%b busy=%b starts=%0d, want 0 0 0",
                         res_valid, busy, start_cnt - s0);
            end
        end
        push_cmd(rand_cmd(1'b0), 3);
        wait_idle(100);
    endtask

    task automatic test_back_to_back();
        int lat;
        rr_random = 1'b1;
        for (int i = 0; i < 24; i++) begin
            lat = int'($urandom_range(2, TIMEOUT));
            if ($urandom_range(0, 7) == 0) begin
                lat = ($urandom_range(0, 1) == 0) ? 0 : TIMEOUT + 1;
                push_cmd(rand_cmd(1'b1), lat);
            end else begin
                push_cmd(rand_cmd(1'b0), lat);
            end
        end
        wait_idle(3000);
        rr_random = 1'b0;
        res_ready = 1'b1;
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_a     = 2'd0;
        cmd_b     = 2'd0;
        cmd_addr  = 4'd0;
        res_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 3'd0;
            alu_mem[i] = 3'd0;
        end
        test_reset();
        test_single();
        test_in_order();
        test_full();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
